// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 64;
  localparam logic [ADDR_W-1:0] PC_STEP = 64'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_VALID = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_e;

  function automatic logic is_aligned(input logic [ADDR_W-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_wait_counter.sv
// Counts memory wait cycles while a fetch holds its address; done_o marks the capture cycle.
module fetch_wait_counter #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic en_i,
  output logic done_o
);

  localparam int unsigned CW = $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == LAST);

endmodule

// File: rtl/imem_fetch_sequencer.sv
// Program counter, fetch FSM and capture registers feeding decode over valid/ready.
// Handshake: Instr/InstrPC are held while InstrValid=1; a transfer happens on a
// rising edge where InstrValid=1 and InstrReady=1, unless Redirect is high that cycle.
module imem_fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC    = 64'h0,
  parameter int unsigned       WAIT_CYCLES = 2,
  parameter logic [ADDR_W-1:0] PC_LIMIT    = 64'h060
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic               Enable,
  output logic [ADDR_W-1:0]  IMemAddress,
  input  logic [INSTR_W-1:0] IMemData,
  input  logic               Redirect,
  input  logic [ADDR_W-1:0]  RedirectPC,
  output logic               InstrValid,
  input  logic               InstrReady,
  output logic [INSTR_W-1:0] Instr,
  output logic [ADDR_W-1:0]  InstrPC,
  output logic               Halted,
  output logic               Fault,
  output logic [1:0]         DbgState
);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  addr_q;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
  logic               fault_q, fault_d;
  logic               cnt_clear, cnt_en, cnt_done;
  logic               redir_ignored;

  fetch_wait_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait (
    .clk_i  (CLK),
    .rst_i  (Reset),
    .clear_i(cnt_clear),
    .en_i   (cnt_en),
    .done_o (cnt_done)
  );

  // Once halted, only a fault-free aligned redirect back into the program restarts fetch.
  assign redir_ignored = (state_q == ST_HALT) && (fault_q || (RedirectPC >= PC_LIMIT));

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    fault_d    = fault_q;
    cnt_clear  = 1'b0;
    cnt_en     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_clear = 1'b1;
        if (Enable) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        cnt_en = 1'b1;
        if (cnt_done) begin
          instr_d    = IMemData;
          instr_pc_d = pc_q;
          pc_d       = pc_q + PC_STEP;
          state_d    = ST_VALID;
        end
      end
      ST_VALID: begin
        cnt_clear = 1'b1;
        if (InstrReady) begin
          if (pc_q >= PC_LIMIT) state_d = ST_HALT;
          else if (Enable)      state_d = ST_FETCH;
          else                  state_d = ST_IDLE;
        end
      end
      default: begin
        cnt_clear = 1'b1;
      end
    endcase

    // Redirect overrides any capture or handshake decided above.
    if (Redirect) begin
      if (!is_aligned(RedirectPC)) begin
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        pc_d       = pc_q;
        fault_d    = 1'b1;
        cnt_clear  = 1'b1;
        cnt_en     = 1'b0;
        state_d    = ST_HALT;
      end else if (!redir_ignored) begin
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        pc_d       = RedirectPC;
        cnt_clear  = 1'b1;
        cnt_en     = 1'b0;
        state_d    = (state_q == ST_IDLE) ? ST_IDLE : ST_FETCH;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      addr_q     <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_q     <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      fault_q    <= fault_d;
    end
  end

  assign IMemAddress = addr_q;
  assign InstrValid  = (state_q == ST_VALID);
  assign Instr       = instr_q;
  assign InstrPC     = instr_pc_q;
  assign Halted      = (state_q == ST_HALT);
  assign Fault       = fault_q;
  assign DbgState    = state_q;

endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// Directed bench for imem_fetch_sequencer against a small combinational instruction ROM.
module tb_imem_fetch_sequencer;
  import fetch_pkg::*;

  logic        CLK = 1'b0;
  logic        Reset, Enable, Redirect, InstrReady;
  logic [63:0] IMemAddress, RedirectPC, InstrPC;
  logic [31:0] IMemData, Instr;
  logic        InstrValid, Halted, Fault;
  logic [1:0]  DbgState;

  logic [31:0] mem [0:31];
  int n_cmp = 0;
  int n_fail = 0;

  imem_fetch_sequencer dut (
    .CLK(CLK), .Reset(Reset), .Enable(Enable), .IMemAddress(IMemAddress),
    .IMemData(IMemData), .Redirect(Redirect), .RedirectPC(RedirectPC),
    .InstrValid(InstrValid), .InstrReady(InstrReady), .Instr(Instr),
    .InstrPC(InstrPC), .Halted(Halted), .Fault(Fault), .DbgState(DbgState)
  );

  // clock / reset
  always #5 CLK = ~CLK;
  assign IMemData = mem[IMemAddress[6:2]];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int max_cycles);
    for (int i = 0; i < max_cycles && InstrValid !== 1'b1; i++) tick();
    chk("wait_valid", {63'd0, InstrValid}, 64'd1);
  endtask

  task automatic fetch_one(input logic [31:0] ei, input logic [63:0] ep);
    wait_valid(8);
    chk("instr", {32'd0, Instr}, {32'd0, ei});
    chk("instr_pc", InstrPC, ep);
    InstrReady = 1'b1;
    tick();
    InstrReady = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_addr"}, IMemAddress, 64'h0);
    chk({tag, "_valid"}, {63'd0, InstrValid}, 64'd0);
    chk({tag, "_instr"}, {32'd0, Instr}, 64'd0);
    chk({tag, "_instr_pc"}, InstrPC, 64'h0);
    chk({tag, "_halted"}, {63'd0, Halted}, 64'd0);
    chk({tag, "_fault"}, {63'd0, Fault}, 64'd0);
    chk({tag, "_state"}, {62'd0, DbgState}, 64'(ST_IDLE));
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    mem[0]  = 32'hF84003E9; mem[1]  = 32'hF84083EA; mem[2]  = 32'hF84103EB;
    mem[3]  = 32'hF84183EC; mem[4]  = 32'h8B0A0129; mem[5]  = 32'hAA0B014A;
    mem[6]  = 32'hCB0C016B; mem[7]  = 32'h8A0D018C; mem[8]  = 32'h8B0901AD;
    mem[9]  = 32'hB40000CE; mem[10] = 32'hCB0E01CF; mem[11] = 32'h17FFFFF0;
    mem[12] = 32'hD2800010; mem[13] = 32'h8A1F0129; mem[14] = 32'hAA090150;
    mem[15] = 32'hF80003F0; mem[16] = 32'h8B100211; mem[17] = 32'hCB110232;
    mem[18] = 32'hAA120253; mem[19] = 32'h8A130274; mem[20] = 32'hF80083F4;
    mem[21] = 32'hF84003EB; mem[22] = 32'hF84203F1; mem[23] = 32'hF84283EA;

    Reset = 1'b1; Enable = 1'b0; Redirect = 1'b0; RedirectPC = '0; InstrReady = 1'b0;
    tick(); tick();
    chk_reset_outputs("reset");
    Reset = 1'b0;

    // streaming with InstrReady held high: one word every 3 cycles
    Enable = 1'b1; InstrReady = 1'b1;
    tick(); chk("lat_c1_valid", {63'd0, InstrValid}, 64'd0);
    tick(); chk("lat_c2_valid", {63'd0, InstrValid}, 64'd0);
    tick();
    chk("first_valid", {63'd0, InstrValid}, 64'd1);
    chk("first_instr", {32'd0, Instr}, 64'hF84003E9);
    chk("first_pc", InstrPC, 64'h0);
    chk("first_addr", IMemAddress, 64'h4);
    tick(); chk("gap1_valid", {63'd0, InstrValid}, 64'd0);
    tick(); chk("gap2_valid", {63'd0, InstrValid}, 64'd0);
    tick();
    chk("second_valid", {63'd0, InstrValid}, 64'd1);
    chk("second_instr", {32'd0, Instr}, 64'hF84083EA);
    InstrReady = 1'b0;

    fetch_one(32'hF84083EA, 64'h04);
    fetch_one(32'hF84103EB, 64'h08);
    fetch_one(32'hF84183EC, 64'h0C);
    fetch_one(32'h8B0A0129, 64'h10);

    // backpressure on the word at 0x014
    wait_valid(8);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {63'd0, InstrValid}, 64'd1);
      chk("bp_instr", {32'd0, Instr}, 64'hAA0B014A);
      chk("bp_pc", InstrPC, 64'h14);
      chk("bp_addr", IMemAddress, 64'h18);
      tick();
    end
    InstrReady = 1'b1;
    tick();
    InstrReady = 1'b0;
    chk("bp_after_valid", {63'd0, InstrValid}, 64'd0);
    chk("bp_after_addr", IMemAddress, 64'h18);

    fetch_one(32'hCB0C016B, 64'h18);
    fetch_one(32'h8A0D018C, 64'h1C);
    fetch_one(32'h8B0901AD, 64'h20);
    fetch_one(32'hB40000CE, 64'h24);

    // redirect to 0x020 while 0x028 is offered and accepted in the same cycle
    wait_valid(8);
    chk("pre_redir_pc", InstrPC, 64'h28);
    Redirect = 1'b1; RedirectPC = 64'h20; InstrReady = 1'b1;
    tick();
    Redirect = 1'b0; InstrReady = 1'b0;
    chk("redir_drop_valid", {63'd0, InstrValid}, 64'd0);
    chk("redir_addr", IMemAddress, 64'h20);
    tick(); chk("redir_c2_valid", {63'd0, InstrValid}, 64'd0);
    tick(); chk("redir_c3_valid", {63'd0, InstrValid}, 64'd1);
    fetch_one(32'h8B0901AD, 64'h20);

    // run to the program limit
    for (int a = 'h24; a <= 'h5C; a += 4) fetch_one(mem[a >> 2], 64'(a));
    chk("limit_halted", {63'd0, Halted}, 64'd1);
    chk("limit_valid", {63'd0, InstrValid}, 64'd0);
    chk("limit_addr", IMemAddress, 64'h60);
    chk("limit_fault", {63'd0, Fault}, 64'd0);
    InstrReady = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("halt_no_valid", {63'd0, InstrValid}, 64'd0);
    end
    InstrReady = 1'b0;

    // resume from halt
    Redirect = 1'b1; RedirectPC = 64'h34;
    tick();
    Redirect = 1'b0;
    chk("resume_halted", {63'd0, Halted}, 64'd0);
    fetch_one(32'h8A1F0129, 64'h34);

    // misaligned redirect faults; later aligned redirect ignored
    Redirect = 1'b1; RedirectPC = 64'h22;
    tick();
    Redirect = 1'b0;
    chk("fault_fault", {63'd0, Fault}, 64'd1);
    chk("fault_halted", {63'd0, Halted}, 64'd1);
    chk("fault_addr", IMemAddress, 64'h38);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("fault_no_valid", {63'd0, InstrValid}, 64'd0);
    end
    Redirect = 1'b1; RedirectPC = 64'h10;
    tick();
    Redirect = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("fault_ign_halted", {63'd0, Halted}, 64'd1);
      chk("fault_ign_fault", {63'd0, Fault}, 64'd1);
      chk("fault_ign_addr", IMemAddress, 64'h38);
      chk("fault_ign_valid", {63'd0, InstrValid}, 64'd0);
      tick();
    end

    // reset mid-count during a fetch
    Reset = 1'b1; tick(); Reset = 1'b0;
    Enable = 1'b1;
    tick();
    chk("mid_state", {62'd0, DbgState}, 64'(ST_FETCH));
    Reset = 1'b1;
    tick();
    chk_reset_outputs("midreset");
    Reset = 1'b0;
    fetch_one(32'hF84003E9, 64'h0);

    // Enable low at the handshake parks in IDLE
    Enable = 1'b0;
    wait_valid(8);
    InstrReady = 1'b1;
    tick();
    InstrReady = 1'b0;
    chk("idle_state", {62'd0, DbgState}, 64'(ST_IDLE));
    tick(); tick();
    chk("idle_valid", {63'd0, InstrValid}, 64'd0);
    chk("idle_addr", IMemAddress, 64'h8);
    Enable = 1'b1;
    tick(); tick();
    chk("reen_c2_valid", {63'd0, InstrValid}, 64'd0);
    tick();
    chk("reen_valid", {63'd0, InstrValid}, 64'd1);
    chk("reen_instr", {32'd0, Instr}, 64'hF84103EB);
    chk("reen_pc", InstrPC, 64'h08);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_fetch_sequencer.md
# imem_fetch_sequencer

Sequences instruction fetches from the read-only instruction memory on behalf of the processor core. Owns the program counter, drives the 64-bit memory address, holds it stable for the memory's read latency, captures the 32-bit word and hands it to decode over a valid/ready handshake. Accepts branch/CBZ redirects from execute and halts at the end of the loaded program.

## Interface
- `RESET_PC`, 64'h0: PC loaded on reset.
- `WAIT_CYCLES`, 2: cycles the address is held before capture; legal range ≥1.
- `PC_LIMIT`, 64'h060: first address past the program; reaching it halts fetch.

- `CLK` input 1: sole clock; all state updates on the rising edge.
- `Reset` input 1: synchronous, active-high reset.
- `Enable` input 1: permits starting new fetches.
- `IMemAddress` output 64: address driven to instruction memory.
- `IMemData` input 32: word returned by instruction memory.
- `Redirect` input 1: single-cycle pulse; replace the PC.
- `RedirectPC` input 64: target PC, sampled when `Redirect`=1.
- `InstrValid` output 1: `Instr`/`InstrPC` hold a fetched instruction.
- `InstrReady` input 1: decode accepts when high with `InstrValid`.
- `Instr` output 32: captured instruction word.
- `InstrPC` output 64: address `Instr` was fetched from.
- `Halted` output 1: fetch stopped (limit reached or fault).
- `Fault` output 1: sticky; misaligned redirect target.

## Operation
- States: IDLE, FETCH, VALID, HALT. Reset → IDLE.
- IDLE: `Enable`=1 → FETCH with counter cleared; otherwise stay.
- FETCH: `IMemAddress`=PC, constant for the whole state. Counter increments each cycle; on the cycle counter == WAIT_CYCLES-1: `Instr`←`IMemData`, `InstrPC`←PC, PC←PC+4, → VALID.
- VALID: `InstrValid`=1; `Instr`/`InstrPC` stable until the handshake. On `InstrReady`=1: if new PC ≥ `PC_LIMIT` → HALT; else if `Enable` → FETCH; else → IDLE.
- HALT: `Halted`=1; no fetches. Leaves only on `Redirect` with aligned target < `PC_LIMIT` (→ FETCH, `Halted` clears) or `Reset`. A redirect while `Fault`=1 is ignored.
- Redirect (any state), aligned target: PC←`RedirectPC`, counter cleared. From FETCH/VALID/HALT → FETCH; from IDLE stay IDLE (fetch starts when `Enable`). In VALID the held instruction is discarded: `InstrValid` drops the next cycle even if `InstrReady` was high in the same cycle (handshake does not count).
- Redirect with `RedirectPC[1:0]`≠0: `Fault`←1, → HALT, PC unchanged.
- Priority: `Reset` > `Redirect` > handshake/counter.
- Arithmetic: PC+4 modulo 2^64; limit compare unsigned. Counter width $clog2(WAIT_CYCLES+1).
- `Enable` low mid-FETCH does not abort; it only blocks the next FETCH start.

## Timing
- Reset values: `IMemAddress`=`RESET_PC`, `InstrValid`=0, `Instr`=0, `InstrPC`=0, `Halted`=0, `Fault`=0, PC=`RESET_PC`.
- `IMemAddress` is registered (equals PC every state, updates the cycle after a PC change).
- Latency: FETCH entry to `InstrValid`=1 is WAIT_CYCLES cycles; with `InstrReady` held high, one instruction per WAIT_CYCLES+1 cycles (3 at default).
- `Halted`/`Fault` assert the cycle after the causing edge.
- Redirect-to-valid: WAIT_CYCLES+1 cycles after the pulse cycle.

## Structure
- Shared package `fetch_pkg`: state enum (IDLE/FETCH/VALID/HALT), instruction width 32, address width 64, PC step 4.
- One sub-module: `fetch_wait_counter` (clear, enable, `done` at WAIT_CYCLES-1); FSM, PC and capture registers stay in the top.

## Test plan
- Reset, `Enable`=1, `InstrReady`=1 with the test program loaded: first `Instr`=F84003E9, `InstrPC`=0; next F84083EA at 0x004; `InstrValid` pulses every 3 cycles.
- Backpressure: `InstrReady`=0 for 5 cycles while `Instr`=AA0B014A (`InstrPC`=0x014) → outputs unchanged, `IMemAddress`=0x018, no new fetch until accept.
- Redirect to 0x020 while VALID at 0x028, `InstrReady`=1 same cycle → that word not counted; next `Instr`=8B0901AD, `InstrPC`=0x020.
- Run to limit 0x060: after accepting F84283EA at 0x05C, `Halted`=1, no further `InstrValid`; redirect to 0x034 → resumes with 8A1F0129.
- Redirect to 0x022 → `Fault`=1, `Halted`=1, `InstrValid` stays 0; later aligned redirect ignored.
- `Reset` asserted during FETCH counter mid-count → next cycle all outputs at reset values, `IMemAddress`=`RESET_PC`.
